matriz_colunas_scan: RTL and testbench



---
 rtl/matriz_pkg.sv | 48 ++++
 rtl/matriz_scan_div.sv | 36 +++
 rtl/matriz_colunas_scan.sv | 140 ++++++++++++++
 tb/tb_matriz_colunas_scan.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared types and helpers for the 2-of-N column scanner: state encoding,
// code-word classification and pair-rank decoding.
package matriz_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Width of the digit output: enough bits to hold every pair rank.
  function automatic int idx_w(input int n);
    int pairs;
    pairs = n * (n - 1) / 2;
    return (pairs <= 2) ? 1 : $clog2(pairs);
  endfunction

  function automatic logic popcount2(input logic [MAX_N-1:0] word);
    int cnt;
    cnt = 0;
    for (int k = 0; k < MAX_N; k++) begin
      if (word[k]) cnt++;
    end
    return (cnt == 2);
  endfunction

  // Rank of the pair (lo,hi) in lexicographic order; only meaningful when
  // exactly two bits are set. Pairs before row lo number lo*(2n-lo-1)/2.
  function automatic int pair_rank(input logic [MAX_N-1:0] word, input int n);
    int lo;
    int hi;
    int cnt;
    lo  = 0;
    hi  = 0;
    cnt = 0;
    for (int k = 0; k < MAX_N; k++) begin
      if (word[k]) begin
        if (cnt == 0) lo = k;
        else if (cnt == 1) hi = k;
        cnt++;
      end
    end
    return (lo * (2 * n - lo - 1)) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/matriz_scan_div.sv
// Column-scan prescaler: divides clk by SCAN_DIV and rotates a one-hot
// column select left on each terminal count, wrapping bit N-1 to bit 0.
module matriz_scan_div #(
  parameter int N        = 5,
  parameter int SCAN_DIV = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         restart,
  output logic [N-1:0] col_sel
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      col_sel <= N'(1);
    end else if (restart) begin
      cnt     <= '0;
      col_sel <= N'(1);
    end else if (run) begin
      if (cnt == LAST) begin
        cnt     <= '0;
        col_sel <= {col_sel[N-2:0], col_sel[N-1]};
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matriz_colunas_scan.sv
// 2-of-N code decoder driving a scanned N-column LED matrix, blinking on
// invalid words. Define MATRIZ_ERR_COUNT_EN to build the saturating error counter.
module matriz_colunas_scan
  import matriz_pkg::*;
#(
  parameter int N         = 5,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250000,
  parameter int ERRCNT_W  = 8,
  parameter int IDX_W     = idx_w(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [N-1:0]        code_in,
  input  logic                code_valid,
  output logic                code_ready,
  output logic [N-1:0]        col_out,
  output logic [IDX_W-1:0]    digit_out,
  output logic                digit_valid,
  output logic                err_flag,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               word_ok;
  logic [MAX_N-1:0]   code_ext;
  logic [IDX_W-1:0]   rank;
  logic [N-1:0]       code_q;
  logic [N-1:0]       col_sel;
  logic [N-1:0]       col_nxt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic               scan_run;
  logic               scan_restart;

  assign code_ready   = enable;
  assign accept       = code_valid && enable;
  assign code_ext     = MAX_N'(code_in);
  assign word_ok      = popcount2(code_ext);
  assign rank         = IDX_W'(pair_rank(code_ext, N));
  assign scan_run     = enable && (state != IDLE);
  assign scan_restart = (state == IDLE);

  matriz_scan_div #(
    .N        (N),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_div (
    .clk     (clk),
    .reset   (reset),
    .run     (scan_run),
    .restart (scan_restart),
    .col_sel (col_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Column drive is computed from the current state and registered, so it
  // trails a state change by one cycle; disabling blanks it on the next edge.
  always_comb begin
    state_nxt = state;
    col_nxt   = '0;
    if (accept) begin
      state_nxt = word_ok ? SHOW : ERROR;
    end
    if (enable) begin
      case (state)
        SHOW:    col_nxt = col_sel & code_q;
        ERROR:   col_nxt = blink_on ? col_sel : '0;
        default: col_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_out <= '0;
    end else begin
      col_out <= col_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q      <= '0;
      digit_out   <= '0;
      digit_valid <= 1'b0;
      err_flag    <= 1'b0;
    end else if (accept) begin
      code_q <= code_in;
      if (word_ok) begin
        digit_out   <= rank;
        digit_valid <= 1'b1;
        err_flag    <= 1'b0;
      end else begin
        digit_valid <= 1'b0;
        err_flag    <= 1'b1;
      end
    end
  end

  // Every bad word restarts the blink lit, even when already in ERROR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (accept && !word_ok) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (enable && state == ERROR) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

`ifdef MATRIZ_ERR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (accept && !word_ok && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_matriz_colunas_scan.sv
// Directed plus randomized bench for matriz_colunas_scan (N=5, SCAN_DIV=4,
// BLINK_DIV=8) against a cycle-count based reference model.
module tb_matriz_colunas_scan;

  localparam int N         = 5;
  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 8;
  localparam int ERRCNT_W  = 8;
  localparam int IDX_W     = 4;
  localparam int ECNT_MAX  = (1 << ERRCNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [N-1:0]        code_in;
  logic                code_valid;
  logic                code_ready;
  logic [N-1:0]        col_out;
  logic [IDX_W-1:0]    digit_out;
  logic                digit_valid;
  logic                err_flag;
  logic [ERRCNT_W-1:0] err_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0=idle 1=show 2=error, scan/blink position from cycle counts.
  int           m_state;
  int           m_active;
  int           m_err_cyc;
  logic [N-1:0] m_code;
  int           m_digit;
  logic         m_dvalid;
  logic         m_eflag;
  int           m_ecount;
  logic [N-1:0] m_col;

  matriz_colunas_scan #(
    .N         (N),
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV),
    .ERRCNT_W  (ERRCNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .code_ready  (code_ready),
    .col_out     (col_out),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .err_flag    (err_flag),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  function automatic int ref_pop(input logic [N-1:0] w);
    int c = 0;
    for (int i = 0; i < N; i++) if (w[i]) c++;
    return c;
  endfunction

  function automatic int ref_rank(input logic [N-1:0] w);
    int r = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (w[i] && w[j]) return r;
        r++;
      end
    end
    return -1;
  endfunction

  function automatic int exp_err_count();
`ifdef MATRIZ_ERR_COUNT_EN
    return m_ecount;
`else
    return 0;
`endif
  endfunction

  task automatic modelReset();
    m_state   = 0;
    m_active  = 0;
    m_err_cyc = 0;
    m_code    = '0;
    m_digit   = 0;
    m_dvalid  = 1'b0;
    m_eflag   = 1'b0;
    m_ecount  = 0;
    m_col     = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".col_out"}, 32'(col_out), 32'(m_col));
    checkOutput({tag, ".digit_out"}, 32'(digit_out), 32'(m_digit));
    checkOutput({tag, ".digit_valid"}, 32'(digit_valid), 32'(m_dvalid));
    checkOutput({tag, ".err_flag"}, 32'(err_flag), 32'(m_eflag));
    checkOutput({tag, ".err_count"}, 32'(err_count), 32'(exp_err_count()));
  endtask

  // One clock cycle: drive inputs, advance the model by the spec rules, check.
  task automatic applyStimulus(input logic en, input logic valid, input logic [N-1:0] word);
    logic [N-1:0] sel;
    logic         lit;
    bit           acc;
    bit           ok;
    enable     = en;
    code_valid = valid;
    code_in    = word;
    #1;
    checkOutput("code_ready", 32'(code_ready), 32'(en));
    @(posedge clk);
    sel = N'(1 << ((m_active / SCAN_DIV) % N));
    lit = (((m_err_cyc / BLINK_DIV) % 2) == 0);
    m_col = '0;
    if (en) begin
      if (m_state == 1) m_col = sel & m_code;
      else if (m_state == 2) m_col = lit ? sel : '0;
    end
    acc = en && valid;
    ok  = (ref_pop(word) == 2);
    if (m_state != 0 && en) m_active++;
    if (acc && !ok) m_err_cyc = 0;
    else if (m_state == 2 && en) m_err_cyc++;
    if (acc) begin
      m_code = word;
      if (ok) begin
        m_state  = 1;
        m_digit  = ref_rank(word);
        m_dvalid = 1'b1;
        m_eflag  = 1'b0;
      end else begin
        m_state  = 2;
        m_dvalid = 1'b0;
        m_eflag  = 1'b1;
        if (m_ecount < ECNT_MAX) m_ecount++;
      end
    end
    #1;
    checkAll("cycle");
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, N'($urandom));
  endtask

  function automatic logic [N-1:0] randPair();
    int i;
    int j;
    i = $urandom_range(0, N - 2);
    j = $urandom_range(i + 1, N - 1);
    return N'((1 << i) | (1 << j));
  endfunction

  function automatic logic [N-1:0] randBad();
    logic [N-1:0] w;
    do begin
      w = N'($urandom_range(0, (1 << N) - 1));
    end while (ref_pop(w) == 2);
    return w;
  endfunction

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    code_valid = 1'b0;
    code_in    = '0;
    modelReset();
    #2;
    checkAll("reset");
    checkOutput("reset.code_ready_off", 32'(code_ready), 32'(0));
    enable = 1'b1;
    #1;
    checkOutput("reset.code_ready_on", 32'(code_ready), 32'(1));
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] valid word 00011 and scan pattern");
    applyStimulus(1'b1, 1'b1, 5'b00011);
    checkOutput("digit_00011", 32'(digit_out), 32'(0));
    checkOutput("dvalid_00011", 32'(digit_valid), 32'(1));
    idleCycles(24);

    $display("[TB] replace word during scan");
    applyStimulus(1'b1, 1'b1, 5'b11000);
    checkOutput("digit_11000", 32'(digit_out), 32'(9));
    idleCycles(6);
    applyStimulus(1'b1, 1'b1, 5'b00110);
    checkOutput("digit_00110", 32'(digit_out), 32'(4));
    idleCycles(10);

    $display("[TB] error words and blink");
    applyStimulus(1'b1, 1'b1, 5'b00111);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 5'b00000);
    checkOutput("eflag_00000", 32'(err_flag), 32'(1));
    checkOutput("dvalid_00000", 32'(digit_valid), 32'(0));
`ifdef MATRIZ_ERR_COUNT_EN
    checkOutput("errcnt_two", 32'(err_count), 32'(2));
`endif
    idleCycles(20);
    applyStimulus(1'b1, 1'b1, 5'b00001);
    idleCycles(11);
    applyStimulus(1'b1, 1'b1, 5'b11111);
    idleCycles(18);

    $display("[TB] error counter saturation");
    for (int k = 0; k < 300; k++) applyStimulus(1'b1, 1'b1, randBad());
`ifdef MATRIZ_ERR_COUNT_EN
    checkOutput("errcnt_sat", 32'(err_count), 32'(255));
`endif
    applyStimulus(1'b1, 1'b1, 5'b01001);
    checkOutput("eflag_01001", 32'(err_flag), 32'(0));
    checkOutput("digit_01001", 32'(digit_out), 32'(2));
    idleCycles(9);

    $display("[TB] enable low freezes scan");
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, 1'b1, N'($urandom));
    checkOutput("disabled_col", 32'(col_out), 32'(0));
    idleCycles(14);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 200; k++) begin
      logic         en;
      logic         vl;
      logic [N-1:0] w;
      en = ($urandom_range(0, 9) != 0);
      vl = ($urandom_range(0, 5) == 0);
      w  = ($urandom_range(0, 2) != 0) ? randPair() : randBad();
      applyStimulus(en, vl, w);
    end

    $display("[TB] asynchronous reset in SHOW");
    applyStimulus(1'b1, 1'b1, 5'b10100);
    idleCycles(2);
    #1;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("async_reset");
    @(negedge clk);
    reset = 1'b0;
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 5'b10001);
    idleCycles(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
